// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX-stage operand
// forwarding from the EX/MEM and MEM/WB stages.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_alu_ctrl,
  input  logic        id_alu_src,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        ex_valid,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] ex_store_data,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        hazard_stall
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_reg_t;

  ex_reg_t     ex_q;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // A load in EX whose destination feeds the instruction in ID must be
  // separated by one bubble; a flush kills ID anyway, so no hazard then.
  assign hazard_stall = !flush && id_valid && ex_q.valid && ex_q.mem_read &&
                        (ex_q.rd != 5'd0) &&
                        ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (stall) begin
      ex_q <= ex_q;
    end else if (hazard_stall) begin
      ex_q <= '0;
    end else begin
      ex_q.valid     <= id_valid;
      ex_q.pc        <= id_pc;
      ex_q.rs1_data  <= id_rs1_data;
      ex_q.rs2_data  <= id_rs2_data;
      ex_q.imm       <= id_imm;
      ex_q.rs1       <= id_rs1;
      ex_q.rs2       <= id_rs2;
      ex_q.rd        <= id_rd;
      ex_q.alu_ctrl  <= id_alu_ctrl;
      // Control bits of an invalid slot are squashed so they cannot leak.
      ex_q.alu_src   <= id_valid & id_alu_src;
      ex_q.reg_write <= id_valid & id_reg_write;
      ex_q.mem_read  <= id_valid & id_mem_read;
      ex_q.mem_write <= id_valid & id_mem_write;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch
    // is inferred.
    fwd_rs1 = ex_q.rs1_data;
    fwd_rs2 = ex_q.rs2_data;

    // EX/MEM is younger than MEM/WB, so it is checked first.
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rs1))
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rs1))
      fwd_rs1 = memwb_result;

    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rs2))
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rs2))
      fwd_rs2 = memwb_result;
  end

  assign ex_valid      = ex_q.valid;
  assign alu_a         = fwd_rs1;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_store_data = fwd_rs2;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic compared against a behavioural model of the EX slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall;

  int errors = 0;
  int checks = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  // Model of the instruction sitting in EX, described as an instruction record.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, a_reg, b_reg, imm;
    logic [4:0]  src1, src2, dst;
    logic [3:0]  op;
    logic        use_imm, wb, load, store;
  } instr_t;

  instr_t m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value of register idx as seen by EX: the newest in-flight producer wins.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] file_val);
    if (idx == 5'd0) return file_val;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    return file_val;
  endfunction

  function automatic logic load_use();
    if (flush || !id_valid || !m.valid || !m.load || m.dst == 5'd0) return 1'b0;
    return (m.dst == id_rs1) || (m.dst == id_rs2);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
    check({tag, ".wb"},    {31'd0, ex_reg_write}, {31'd0, m.wb});
    check({tag, ".load"},  {31'd0, ex_mem_read},  {31'd0, m.load});
    check({tag, ".store"}, {31'd0, ex_mem_write}, {31'd0, m.store});
    check({tag, ".haz"},   {31'd0, hazard_stall}, {31'd0, load_use()});
    if (m.valid) begin
      check({tag, ".pc"},    ex_pc, m.pc);
      check({tag, ".rd"},    {27'd0, ex_rd}, {27'd0, m.dst});
      check({tag, ".op"},    {28'd0, alu_ctrl}, {28'd0, m.op});
      check({tag, ".a"},     alu_a, operand(m.src1, m.a_reg));
      check({tag, ".b"},     alu_b, m.use_imm ? m.imm : operand(m.src2, m.b_reg));
      check({tag, ".sd"},    ex_store_data, operand(m.src2, m.b_reg));
    end
  endtask

  // Advance one rising edge, moving the model by the same rules.
  task automatic clock_edge();
    instr_t nxt;
    if (flush || load_use() && !stall) nxt = '0;
    else if (stall) nxt = m;
    else begin
      nxt = '{valid: id_valid, pc: id_pc, a_reg: id_rs1_data, b_reg: id_rs2_data,
              imm: id_imm, src1: id_rs1, src2: id_rs2, dst: id_rd, op: id_alu_ctrl,
              use_imm: id_valid & id_alu_src, wb: id_valid & id_reg_write,
              load: id_valid & id_mem_read, store: id_valid & id_mem_write};
    end
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_ctrl = 0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic load_instr(input logic [31:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [4:0] d, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [3:0] op, input logic src,
                            input logic wb, input logic ld, input logic st);
    id_valid = 1; id_pc = pc; id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_rs1_data = v1; id_rs2_data = v2; id_imm = imm; id_alu_ctrl = op;
    id_alu_src = src; id_reg_write = wb; id_mem_read = ld; id_mem_write = st;
  endtask

  task automatic pulse_reset();
    rst = 1;
    #1;
    m = '0;
    check_all("rst_async");
    check("rst_async.op0", {28'd0, alu_ctrl}, 32'd0);
    rst = 0;
  endtask

  task automatic randomize_inputs();
    id_valid = ($urandom_range(0, 3) != 0);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7)); id_alu_ctrl = 4'($urandom);
    id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
    id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
    stall = ($urandom_range(0, 5) == 0); flush = ($urandom_range(0, 7) == 0);
    exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
    memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
  endtask

  initial begin
    logic [31:0] held_pc;
    idle_inputs();
    rst = 1;
    m = '0;
    #2;
    check_all("reset");
    check("reset.op0", {28'd0, alu_ctrl}, 32'd0);
    check("reset.pc0", ex_pc, 32'd0);
    rst = 0;

    // Plain capture with ADD.
    load_instr(32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 4'b0010, 0, 1, 0, 0);
    clock_edge();
    idle_inputs();
    #1;
    check_all("capture");
    check("capture.a5", alu_a, 32'd5);
    check("capture.b7", alu_b, 32'd7);

    // Forwarding priority on rs1 = x3.
    load_instr(32'h104, 5'd3, 5'd0, 5'd6, 32'h99, 32'h0, 32'd0, 4'b0001, 0, 1, 0, 0);
    clock_edge();
    idle_inputs();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h22;
    #1;
    check("fwd.exmem", alu_a, 32'h11);
    exmem_reg_write = 0;
    #1;
    check("fwd.memwb", alu_a, 32'h22);
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    #1;
    check("fwd.x0", alu_a, 32'h99);
    check_all("fwd");

    // Load-use: lw x4 in EX, consumer reads x4 as rs2.
    idle_inputs();
    load_instr(32'h200, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 32'd8, 4'b0010, 1, 1, 1, 0);
    clock_edge();
    load_instr(32'h204, 5'd5, 5'd4, 5'd9, 32'h1, 32'h2, 32'd0, 4'b0110, 0, 1, 0, 0);
    #1;
    check("lu.haz", {31'd0, hazard_stall}, 32'd1);
    clock_edge();
    check_all("lu.bubble");
    clock_edge();
    check_all("lu.recapture");
    check("lu.pc", ex_pc, 32'h204);

    // Flush beats stall, then a three-cycle freeze.
    load_instr(32'h300, 5'd1, 5'd2, 5'd7, 32'h3, 32'h4, 32'd0, 4'b0000, 0, 1, 0, 0);
    clock_edge();
    stall = 1; flush = 1;
    clock_edge();
    check_all("flush_stall");
    check("flush_stall.wb0", {31'd0, ex_reg_write}, 32'd0);
    stall = 0; flush = 0;
    load_instr(32'h400, 5'd1, 5'd2, 5'd8, 32'hA, 32'hB, 32'd0, 4'b0001, 0, 1, 0, 1);
    clock_edge();
    held_pc = 32'h400;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = $urandom; id_rs1_data = $urandom; id_alu_ctrl = 4'($urandom);
      clock_edge();
      check_all("stall");
      check("stall.pc", ex_pc, held_pc);
    end

    // Async reset mid-stall, then a normal capture.
    pulse_reset();
    stall = 0;
    load_instr(32'h500, 5'd2, 5'd3, 5'd4, 32'h10, 32'h20, 32'd0, 4'b0110, 0, 1, 0, 0);
    clock_edge();
    check_all("post_reset");
    check("post_reset.valid", {31'd0, ex_valid}, 32'd1);

    // Immediate select with rs2 forwarded to the store data path.
    idle_inputs();
    load_instr(32'h600, 5'd1, 5'd5, 5'd0, 32'h0, 32'h1, 32'hFFFF_FFFC, 4'b0010, 1, 0, 0, 1);
    clock_edge();
    idle_inputs();
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h55;
    #1;
    check("imm.b", alu_b, 32'hFFFF_FFFC);
    check("imm.sd", ex_store_data, 32'h55);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      #1;
      check_all("rand");
      if (n % 97 == 50) pulse_reset();
      else clock_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
